drum_sequencer: RTL
===================

# drum_sequencer

Step sequencer that schedules the drum voice players (snare, kick, hi-hat, clap sample players, each a ROM address counter driven by `en`/`go`). It generates the shared sample-rate enable and, on each step of a 16-step, writable pattern, issues one-cycle `go` pulses to the voices whose pattern bit is set. It sits between the user-control logic (switches/keys) and the voice player instances; voice outputs are mixed downstream.

## Interface
Parameters:
- `VOICES`, 4, number of voice players (bit v of `go`/`mute`/pattern row v).
- `STEPS`, 16, pattern length; step index width is 4.
- `SAMPLE_DIV`, 6250, clk cycles per sample tick (50 MHz / 8 kHz); must be ≥ 2.
- `DIV_W`, 12, width of `tempo_div`.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `run` in 1: level; 1 = play pattern, 0 = stop.
- `tempo_div` in DIV_W: sample ticks per step; 0 treated as 1.
- `mute` in VOICES: bit v set suppresses `go[v]`.
- `pat_we` in 1: pattern write strobe.
- `pat_voice` in 2: voice row to write.
- `pat_step` in 4: step column to write.
- `pat_data` in 1: bit value written.
- `sample_en` out 1: one-cycle sample tick, fed to every voice `en`.
- `go` out VOICES: one-cycle trigger per voice.
- `step_pulse` out 1: one-cycle pulse on every step fire (LED/metronome).
- `step_idx` out 4: step currently playing.
- `playing` out 1: high in ARMED or RUN.

## Operation
- Sample divider: free-running 0..SAMPLE_DIV-1, unaffected by `run`, so voices keep playing out after stop. `sample_en` high when divider at SAMPLE_DIV-1.
- Pattern: VOICES×STEPS bit array, all 0 after reset. Write when `pat_we`: `pattern[pat_voice][pat_step] <= pat_data`, any state. `pat_voice` ≥ VOICES ignored.
- FSM states:
  - IDLE: `playing`=0. `run`=1 → ARMED.
  - ARMED: `playing`=1. On next `sample_en`: fire step 0, load tick counter, → RUN. `run`=0 → IDLE (no fire).
  - RUN: tick counter decrements on each `sample_en`; when it would reach 0, advance `step_idx` (15 wraps to 0), fire step, reload counter from current `tempo_div` (max(tempo_div,1)). `run`=0 → IDLE immediately; no further `go`.
- Step fire (same cycle as a `sample_en` pulse): `step_pulse`=1; `go[v]` = `pattern[v][s] & ~mute[v]` for new step s.
- `step_idx` holds last value in IDLE; reset to 0 on ARMED→RUN.
- `tempo_div` sampled only at reload; changes take effect at next step.
- Write to the step being fired in the same cycle: `go` uses old pattern value (read before write).
- `run` toggled 1→0→1 within one sample period: ends in ARMED; next fire is step 0.
- Reset mid-playback: FSM → IDLE, divider, counter, `step_idx`, pattern cleared; all outputs 0 in the cycle after the reset edge.

## Timing
- All outputs registered; reset value 0 for `sample_en`, `go`, `step_pulse`, `step_idx`, `playing`.
- First `sample_en` in the SAMPLE_DIV-th cycle after reset deasserts, then exactly every SAMPLE_DIV cycles.
- `go`, `step_pulse`, `step_idx` update are coincident with `sample_en` (same cycle) so a voice counter starts at the tick it samples.
- Start latency: first fire on first `sample_en` strictly after the cycle `run` is first sampled 1 (≤ SAMPLE_DIV cycles).
- Step period: `max(tempo_div,1)` × SAMPLE_DIV cycles exactly, no drift.
- Stop latency: `playing` falls one cycle after `run` sampled 0.

## Test plan
- Reset/divider: SAMPLE_DIV=4, hold reset 3 cycles, release → all outputs 0 during reset; `sample_en` in cycles 4, 8, 12…, never two consecutive.
- Basic play: pattern v1 steps {0,4,8,12}, v0 step 0, tempo_div=2, run=1 → `go`=4'b0011 at first fire, `go[1]` every 8 sample ticks, `step_idx` 0→1→…→15→0, `step_pulse` every 8 clk cycles.
- Mute and write collision: `mute`=4'b0010 → `go[1]` never asserts; write pattern[0][5]=1 in the cycle step 5 fires → no `go[0]` that pass, `go[0]` on step 5 of next pass.
- tempo_div=0 and change: tempo_div=0 → step every sample tick; change to 3 mid-step → current step length unchanged, following steps 3 ticks.
- Stop/restart: run=0 at step 7 → `playing`=0 next cycle, no `go`, `step_idx` holds 7, `sample_en` continues; run=1 → next fire is step 0.
- Reset mid-run: assert reset at step 9 → outputs 0, pattern cleared; after release with run=1 and no writes, `go` stays 0 while `step_pulse` fires.

Source files
------------

// File: rtl/drum_sequencer.sv
// Drum step sequencer: free-running sample-rate tick plus a 16-step writable
// trigger pattern that fires one-cycle go pulses to the voice players.
module drum_sequencer #(
    parameter int VOICES     = 4,
    parameter int STEPS      = 16,
    parameter int SAMPLE_DIV = 6250,
    parameter int DIV_W      = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [DIV_W-1:0]  tempo_div,
    input  logic [VOICES-1:0] mute,
    input  logic              pat_we,
    input  logic [1:0]        pat_voice,
    input  logic [3:0]        pat_step,
    input  logic              pat_data,
    output logic              sample_en,
    output logic [VOICES-1:0] go,
    output logic              step_pulse,
    output logic [3:0]        step_idx,
    output logic              playing
);

    typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

    localparam int CW = $clog2(SAMPLE_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(SAMPLE_DIV - 1);
    localparam logic [CW-1:0] DIV_PRE  = CW'(SAMPLE_DIV - 2);

    state_t                         state, state_next;
    logic [CW-1:0]                  div_cnt;
    logic [DIV_W-1:0]               tick_cnt, cnt_next, reload;
    logic [3:0]                     step_next;
    logic [VOICES-1:0][STEPS-1:0]   pattern;
    logic [VOICES-1:0]              col, trig;
    logic                           tick_next, fire;

    // Registered outputs appear one cycle after the decision, so every step
    // decision is keyed on the cycle before the sample tick becomes visible.
    assign tick_next = (div_cnt == DIV_PRE);
    assign reload    = (tempo_div == '0) ? DIV_W'(1) : tempo_div;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_next = state;
        fire       = 1'b0;
        cnt_next   = tick_cnt;
        step_next  = step_idx;
        unique case (state)
            IDLE: begin
                if (run) state_next = ARMED;
            end
            ARMED: begin
                if (!run) begin
                    state_next = IDLE;
                end else if (tick_next) begin
                    fire       = 1'b1;
                    step_next  = 4'd0;
                    cnt_next   = reload;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!run) begin
                    state_next = IDLE;
                end else if (tick_next) begin
                    if (tick_cnt <= DIV_W'(1)) begin
                        fire      = 1'b1;
                        step_next = step_idx + 4'd1;
                        cnt_next  = reload;
                    end else begin
                        cnt_next = tick_cnt - DIV_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        for (int v = 0; v < VOICES; v++) col[v] = pattern[v][step_next];
        trig = fire ? (col & ~mute) : '0;
    end

    // NOTE: state updates use non-blocking assignments so all registers sample
    // the pre-edge values; this is also what makes go read the pattern before
    // a same-cycle write lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            div_cnt    <= '0;
            tick_cnt   <= '0;
            step_idx   <= '0;
            // NOTE: the pattern array is flop-based and must clear on reset, so
            // it cannot be mapped onto a RAM macro.
            pattern    <= '0;
            sample_en  <= 1'b0;
            go         <= '0;
            step_pulse <= 1'b0;
            playing    <= 1'b0;
        end else begin
            state      <= state_next;
            div_cnt    <= (div_cnt == DIV_LAST) ? '0 : div_cnt + CW'(1);
            tick_cnt   <= cnt_next;
            step_idx   <= step_next;
            sample_en  <= tick_next;
            go         <= trig;
            step_pulse <= fire;
            playing    <= (state_next != IDLE);
            if (pat_we && (32'(pat_voice) < VOICES))
                pattern[pat_voice][pat_step] <= pat_data;
        end
    end

endmodule
